// File: rtl/execute_stage.sv
// EX stage: ALU, branch resolution and a shift-add multiplier that holds the front end while it iterates.
// Single-cycle ops reach EX/MEM one edge later; a multiply occupies 16 stall cycles and lands on the 17th edge.
module execute_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] pc_plus_two,
   input  logic [15:0] read_data_1,
   input  logic [15:0] read_data_2,
   input  logic [15:0] immediate,
   input  logic        alu_src,
   input  logic        reg_dest,
   input  logic        branch,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic        mem_to_reg,
   input  logic        reg_write,
   input  logic [1:0]  alu_op,
   input  logic [2:0]  rt,
   input  logic [2:0]  rd,
   input  logic        flush,
   output logic        stall,
   output logic [15:0] O_alu_result,
   output logic [15:0] O_write_data,
   output logic [15:0] O_branch_target,
   output logic [2:0]  O_write_reg,
   output logic        O_zero,
   output logic        O_branch_taken,
   output logic        O_mem_read,
   output logic        O_mem_write,
   output logic        O_mem_to_reg,
   output logic        O_reg_write
);

   typedef enum logic {IDLE, MUL_BUSY} state_t;

   state_t      state;
   logic [3:0]  count;
   logic [15:0] acc;
   logic [15:0] mcand;
   logic [15:0] mplier;

   logic [15:0] op_a;
   logic [15:0] op_b;
   logic [3:0]  funct;
   logic        is_mul;
   logic [15:0] alu_result;
   logic [15:0] acc_next;
   logic [15:0] ex_result;
   logic        do_load;
   logic        do_bubble;

   assign op_a   = read_data_1;
   assign op_b   = alu_src ? immediate : read_data_2;
   assign funct  = immediate[3:0];
   assign is_mul = (alu_op == 2'b10) && (funct == 4'b1000);

   always_comb begin
      alu_result = 16'h0000;
      case (alu_op)
         2'b00: alu_result = op_a + op_b;
         2'b01: alu_result = op_a - op_b;
         2'b11: alu_result = {15'd0, $signed(op_a) < $signed(op_b)};
         default: begin
            case (funct)
               4'b0000: alu_result = op_a + op_b;
               4'b0001: alu_result = op_a - op_b;
               4'b0010: alu_result = op_a & op_b;
               4'b0011: alu_result = op_a | op_b;
               4'b0100: alu_result = op_a ^ op_b;
               4'b0101: alu_result = {15'd0, $signed(op_a) < $signed(op_b)};
               4'b0110: alu_result = op_a << op_b[3:0];
               4'b0111: alu_result = op_a >> op_b[3:0];
               default: alu_result = 16'h0000;
            endcase
         end
      endcase
   end

   // Multiplicand shifts left and multiplier right, so bit 0 of mplier is always the current LSB.
   assign acc_next  = acc + (mplier[0] ? mcand : 16'h0000);
   assign ex_result = (state == MUL_BUSY) ? acc_next : alu_result;

   assign stall = ((state == IDLE) && is_mul && !flush) ||
                  ((state == MUL_BUSY) && (count != 4'd15));

   always_comb begin
      do_load   = 1'b0;
      do_bubble = 1'b0;
      if (flush) begin
         do_bubble = 1'b1;
      end else if (state == IDLE) begin
         do_load   = !is_mul;
         do_bubble = is_mul;
      end else begin
         do_load   = (count == 4'd15);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         count           <= 4'd0;
         acc             <= 16'h0000;
         mcand           <= 16'h0000;
         mplier          <= 16'h0000;
         O_alu_result    <= 16'h0000;
         O_write_data    <= 16'h0000;
         O_branch_target <= 16'h0000;
         O_write_reg     <= 3'd0;
         O_zero          <= 1'b0;
         O_branch_taken  <= 1'b0;
         O_mem_read      <= 1'b0;
         O_mem_write     <= 1'b0;
         O_mem_to_reg    <= 1'b0;
         O_reg_write     <= 1'b0;
      end else begin
         if (flush) begin
            state <= IDLE;
            count <= 4'd0;
         end else if (state == IDLE) begin
            if (is_mul) begin
               mcand  <= read_data_1;
               mplier <= read_data_2;
               acc    <= 16'h0000;
               count  <= 4'd0;
               state  <= MUL_BUSY;
            end
         end else begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 4'd1;
            if (count == 4'd15) begin
               state <= IDLE;
            end
         end

         if (do_load) begin
            O_alu_result    <= ex_result;
            O_zero          <= (ex_result == 16'h0000);
            O_write_data    <= read_data_2;
            O_branch_target <= pc_plus_two + {immediate[14:0], 1'b0};
            O_write_reg     <= reg_dest ? rd : rt;
            O_branch_taken  <= branch && (read_data_1 == read_data_2);
            O_mem_read      <= mem_read;
            O_mem_write     <= mem_write;
            O_mem_to_reg    <= mem_to_reg;
            O_reg_write     <= reg_write;
         end else if (do_bubble) begin
            O_alu_result    <= 16'h0000;
            O_zero          <= 1'b0;
            O_write_data    <= 16'h0000;
            O_branch_target <= 16'h0000;
            O_write_reg     <= 3'd0;
            O_branch_taken  <= 1'b0;
            O_mem_read      <= 1'b0;
            O_mem_write     <= 1'b0;
            O_mem_to_reg    <= 1'b0;
            O_reg_write     <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_execute_stage.sv
// Random + directed bench for execute_stage against a transaction-level reference model.
module tb_execute_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] pc_plus_two, read_data_1, read_data_2, immediate;
   logic        alu_src, reg_dest, branch, mem_read, mem_write, mem_to_reg, reg_write;
   logic [1:0]  alu_op;
   logic [2:0]  rt, rd;
   logic        flush;
   logic        stall;
   logic [15:0] O_alu_result, O_write_data, O_branch_target;
   logic [2:0]  O_write_reg;
   logic        O_zero, O_branch_taken, O_mem_read, O_mem_write, O_mem_to_reg, O_reg_write;

   always #5 clk = ~clk;

   execute_stage dut (
      .clk(clk), .rst(rst),
      .pc_plus_two(pc_plus_two), .read_data_1(read_data_1), .read_data_2(read_data_2),
      .immediate(immediate), .alu_src(alu_src), .reg_dest(reg_dest), .branch(branch),
      .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
      .alu_op(alu_op), .rt(rt), .rd(rd), .flush(flush), .stall(stall),
      .O_alu_result(O_alu_result), .O_write_data(O_write_data), .O_branch_target(O_branch_target),
      .O_write_reg(O_write_reg), .O_zero(O_zero), .O_branch_taken(O_branch_taken),
      .O_mem_read(O_mem_read), .O_mem_write(O_mem_write), .O_mem_to_reg(O_mem_to_reg),
      .O_reg_write(O_reg_write)
   );

   int errors = 0;
   int checks = 0;

   // Expected EX/MEM contents plus the multiply in flight (cycles left and latched operands).
   logic [15:0] e_alu, e_wd, e_bt;
   logic [2:0]  e_wr;
   logic        e_zero, e_btk, e_mr, e_mw, e_m2r, e_rw;
   int          busy_left;
   logic [15:0] ma, mb;

   task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] ref_alu(input logic [1:0] op, input logic [3:0] f,
                                           input logic [15:0] a, input logic [15:0] b);
      int sa, sb;
      logic [3:0] sh;
      sa = int'($signed(a));
      sb = int'($signed(b));
      sh = b[3:0];
      if (op == 2'b00) return a + b;
      if (op == 2'b01) return a - b;
      if (op == 2'b11) return (sa < sb) ? 16'h0001 : 16'h0000;
      case (f)
         4'h0: return a + b;
         4'h1: return a - b;
         4'h2: return a & b;
         4'h3: return a | b;
         4'h4: return a ^ b;
         4'h5: return (sa < sb) ? 16'h0001 : 16'h0000;
         4'h6: return a << sh;
         4'h7: return a >> sh;
         default: return 16'h0000;
      endcase
   endfunction

   function automatic logic in_is_mul();
      return (alu_op == 2'b10) && (immediate[3:0] == 4'h8);
   endfunction

   function automatic logic model_stall();
      return (busy_left == 0 && in_is_mul() && !flush) || (busy_left > 1);
   endfunction

   task automatic model_bubble();
      e_alu = 0; e_wd = 0; e_bt = 0; e_wr = 0;
      e_zero = 0; e_btk = 0; e_mr = 0; e_mw = 0; e_m2r = 0; e_rw = 0;
   endtask

   task automatic model_reset();
      model_bubble();
      busy_left = 0;
   endtask

   task automatic model_load(input logic [15:0] res);
      e_alu  = res;
      e_zero = (res == 16'h0000);
      e_wd   = read_data_2;
      e_bt   = pc_plus_two + 16'(immediate * 2);
      e_wr   = reg_dest ? rd : rt;
      e_btk  = branch && (read_data_1 == read_data_2);
      e_mr   = mem_read; e_mw = mem_write; e_m2r = mem_to_reg; e_rw = reg_write;
   endtask

   // Advance the model across one rising edge using the inputs present at that edge.
   task automatic model_step();
      logic [15:0] prod;
      if (flush) begin
         model_bubble();
         busy_left = 0;
      end else if (busy_left > 0) begin
         busy_left--;
         if (busy_left == 0) begin
            prod = ma * mb;
            model_load(prod);
         end
      end else if (in_is_mul()) begin
         ma = read_data_1;
         mb = read_data_2;
         busy_left = 16;
         model_bubble();
      end else begin
         model_load(ref_alu(alu_op, immediate[3:0], read_data_1,
                            alu_src ? immediate : read_data_2));
      end
   endtask

   task automatic check_outputs();
      chk16("alu_result", O_alu_result, e_alu);
      chk16("write_data", O_write_data, e_wd);
      chk16("branch_target", O_branch_target, e_bt);
      chk16("write_reg", {13'd0, O_write_reg}, {13'd0, e_wr});
      chk1("zero", O_zero, e_zero);
      chk1("branch_taken", O_branch_taken, e_btk);
      chk1("mem_read", O_mem_read, e_mr);
      chk1("mem_write", O_mem_write, e_mw);
      chk1("mem_to_reg", O_mem_to_reg, e_m2r);
      chk1("reg_write", O_reg_write, e_rw);
   endtask

   // Called a little after a rising edge with inputs already applied.
   task automatic tick(output logic s);
      #1;
      s = stall;
      chk1("stall", stall, model_stall());
      model_step();
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic clear_inputs();
      pc_plus_two = 0; read_data_1 = 0; read_data_2 = 0; immediate = 0;
      alu_src = 0; reg_dest = 0; branch = 0; mem_read = 0; mem_write = 0;
      mem_to_reg = 0; reg_write = 0; alu_op = 0; rt = 0; rd = 0; flush = 0;
   endtask

   task automatic rand_inputs();
      pc_plus_two = 16'($urandom); read_data_1 = 16'($urandom);
      read_data_2 = 16'($urandom); immediate = 16'($urandom);
      if ($urandom_range(0, 3) == 0) read_data_2 = read_data_1;
      if ($urandom_range(0, 2) == 0) read_data_2 = 16'($urandom_range(0, 20));
      alu_src = 1'($urandom); reg_dest = 1'($urandom); branch = 1'($urandom);
      mem_read = 1'($urandom); mem_write = 1'($urandom);
      mem_to_reg = 1'($urandom); reg_write = 1'($urandom);
      alu_op = 2'($urandom); rt = 3'($urandom); rd = 3'($urandom);
      if ($urandom_range(0, 5) == 0) begin
         alu_op = 2'b10;
         immediate[3:0] = 4'h8;
      end
      flush = ($urandom_range(0, 15) == 0);
   endtask

   initial begin
      logic s;
      int   n;

      clear_inputs();
      rst = 1'b1;
      model_reset();
      #2;
      check_outputs();
      chk1("reset_stall_idle", stall, 1'b0);
      alu_op = 2'b10; immediate = 16'h0008;
      #1;
      chk1("reset_stall_mul_decoded", stall, 1'b1);
      clear_inputs();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // add via funct: FFFF + 0002 wraps to 0001
      alu_op = 2'b10; immediate = 16'h0000; read_data_1 = 16'hFFFF; read_data_2 = 16'h0002;
      tick(s);
      chk16("lit_add_wrap", O_alu_result, 16'h0001);
      chk1("lit_add_zero", O_zero, 1'b0);

      // signed slt: 8000 (negative) < 0001
      immediate = 16'h0005; read_data_1 = 16'h8000; read_data_2 = 16'h0001;
      tick(s);
      chk16("lit_slt_signed", O_alu_result, 16'h0001);

      // taken branch with negative offset
      clear_inputs();
      branch = 1'b1; read_data_1 = 16'h0005; read_data_2 = 16'h0005;
      pc_plus_two = 16'h0010; immediate = 16'hFFFE;
      tick(s);
      chk1("lit_branch_taken", O_branch_taken, 1'b1);
      chk16("lit_branch_target", O_branch_target, 16'h000C);

      // multiply held stable for its whole occupancy
      clear_inputs();
      alu_op = 2'b10; immediate = 16'h0008; read_data_1 = 16'h0123; read_data_2 = 16'h0010;
      reg_write = 1'b1;
      n = 0;
      for (int g = 0; g < 40; g++) begin
         tick(s);
         if (!s) break;
         n++;
      end
      chk16("lit_mul_stall_cycles", 16'(n), 16'd16);
      chk16("lit_mul_result", O_alu_result, 16'h1230);
      chk1("lit_mul_reg_write", O_reg_write, 1'b1);

      // flush at iteration 7 of a multiply
      tick(s);
      for (int k = 0; k < 7; k++) tick(s);
      flush = 1'b1;
      tick(s);
      chk1("lit_flush_bubble_rw", O_reg_write, 1'b0);
      clear_inputs();
      alu_op = 2'b01; read_data_1 = 16'h0009; read_data_2 = 16'h0004; reg_write = 1'b1;
      #1;
      chk1("lit_flush_idle_stall", stall, 1'b0);
      tick(s);
      chk16("lit_after_flush_sub", O_alu_result, 16'h0005);

      // reset at iteration 10 of a multiply
      clear_inputs();
      alu_op = 2'b10; immediate = 16'h0008; read_data_1 = 16'h7777; read_data_2 = 16'hFFFF;
      reg_write = 1'b1;
      for (int k = 0; k < 11; k++) tick(s);
      rst = 1'b1;
      model_reset();
      #2;
      check_outputs();
      chk16("lit_rst_alu", O_alu_result, 16'h0000);
      clear_inputs();
      alu_op = 2'b00; read_data_1 = 16'h0002; read_data_2 = 16'h0003; reg_write = 1'b1;
      rst = 1'b0;
      #1;
      chk1("lit_rst_stall", stall, 1'b0);
      tick(s);
      chk16("lit_after_rst_add", O_alu_result, 16'h0005);

      // random traffic; the front end holds inputs while stalled
      s = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if (s) flush = ($urandom_range(0, 19) == 0);
         else rand_inputs();
         tick(s);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; ports named clk and rst.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  async active-high reset.
REQ-004 pc_plus_two, read_data_1, read_data_2, immediate  in  16 each  operands from ID_EX.
REQ-005 alu_src, reg_dest, branch, mem_read, mem_write, mem_to_reg, reg_write  in  1 each  controls from ID_EX.
REQ-006 alu_op  in  2  ALU class; rt, rd  in  3 each  destination candidates.
REQ-007 flush  in  1  kill current instruction; forces a bubble.
REQ-008 stall  out  1  hold IF/ID and ID_EX; combinational from state and inputs.
REQ-009 O_alu_result, O_write_data, O_branch_target  out  16 each  registered EX/MEM data.
REQ-010 O_write_reg  out  3; O_zero, O_branch_taken, O_mem_read, O_mem_write, O_mem_to_reg, O_reg_write  out  1 each  registered.

Function
REQ-011 Operand A = read_data_1; operand B = immediate if alu_src=1, else read_data_2.
REQ-012 alu_op: 00 add, 01 sub, 11 signed slt; 10 decodes funct = immediate[3:0].
REQ-013 funct: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 signed slt, 0110 A<<B[3:0], 0111 logical A>>B[3:0], 1000 mul; all others give result 0.
REQ-014 Add/sub/shift/mul wrap modulo 2^16; no overflow flag; slt yields 16'h0001 or 16'h0000.
REQ-015 Every output updates only on the rising clk edge (one-cycle latency for single-cycle ops).
REQ-016 O_zero = (result == 0); O_write_data = read_data_2; O_write_reg = rd if reg_dest=1, else rt.
REQ-017 O_branch_taken = branch & (read_data_1 == read_data_2); O_branch_target = pc_plus_two + (immediate<<1), 16-bit wrap.
REQ-018 FSM states IDLE and MUL_BUSY, with a 4-bit iteration counter.
REQ-019 IDLE with mul decoded and flush=0: latch A and read_data_2 (alu_src ignored), clear accumulator, counter=0, go MUL_BUSY, stall=1, EX/MEM gets bubble.
REQ-020 MUL_BUSY: one shift-add iteration per cycle, multiplier LSB first; counter increments each cycle.
REQ-021 stall = (IDLE & mul decoded & !flush) | (MUL_BUSY & counter != 15).
REQ-022 MUL_BUSY with counter=15: stall=0; EX/MEM loads low 16 bits of product plus the current input controls; go IDLE.
REQ-023 Mul occupancy: stall high 16 consecutive cycles; product visible after the 17th edge from entry.
REQ-024 Bubble = O_mem_read, O_mem_write, O_reg_write, O_mem_to_reg, O_branch_taken all 0; data outputs don't-care but driven to 0.
REQ-025 flush=1 in any state: next edge loads bubble, FSM to IDLE, counter cleared; flush beats mul start and mul completion.
REQ-026 Controls of a stalled mul SHALL NOT be sampled before completion; the held ID_EX input supplies them at REQ-022.

Reset
REQ-027 rst=1: FSM IDLE, counter 0, accumulator 0, all registered outputs 0, stall reflects IDLE equation.
REQ-028 rst asserted during MUL_BUSY aborts the multiply; no partial product reaches outputs.

Verification
REQ-029 alu_op=10, funct=0000, A=16'hFFFF, B=16'h0002 -> O_alu_result=16'h0001, O_zero=0, one edge later.
REQ-030 alu_op=10, funct=0101, A=16'h8000, B=16'h0001 -> O_alu_result=16'h0001 (signed).
REQ-031 branch=1, rd1=rd2=16'h0005, pc_plus_two=16'h0010, imm=16'hFFFE -> O_branch_taken=1, O_branch_target=16'h000C.
REQ-032 mul A=16'h0123, B=16'h0010 held stable -> stall high exactly 16 cycles; O_alu_result=16'h1230 with O_reg_write=1.
REQ-033 mul started, flush=1 at iteration 7 -> next edge bubble, stall=0, FSM IDLE.
REQ-034 rst pulsed at iteration 10 of a mul -> all outputs 0, stall=0 after release with non-mul input.
